ps2_scancode_ascii: RTL and testbench

Converts the raw PS/2 Set-2 byte stream from the PS/2 receiver into ASCII characters for the general register and 7-segment path.
- Tracks the make, break (F0) and extended (E0) prefixes.
- Emits one ASCII byte plus a one-cycle valid strobe per key press; break codes produce no output.
- Sits directly downstream of the PS/2 receiver and upstream of the general register.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_ascii_lut.sv | 50 +++++
 rtl/ps2_scancode_ascii.sv | 112 +++++++++++
 tb/tb_ps2_scancode_ascii.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scancode constants for the PS/2 Set-2 to ASCII translator.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational Set-2 make code to ASCII table: letters, digits, space, enter, backspace.
module ps2_ascii_lut (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       hit
);

  logic [7:0] w_char;
  logic       w_letter;

  always_comb begin
    w_char   = 8'h00;
    w_letter = 1'b1;
    hit      = 1'b1;
    case (code)
      8'h1C: w_char = 8'h61;  8'h32: w_char = 8'h62;  8'h21: w_char = 8'h63;
      8'h23: w_char = 8'h64;  8'h24: w_char = 8'h65;  8'h2B: w_char = 8'h66;
      8'h34: w_char = 8'h67;  8'h33: w_char = 8'h68;  8'h43: w_char = 8'h69;
      8'h3B: w_char = 8'h6A;  8'h42: w_char = 8'h6B;  8'h4B: w_char = 8'h6C;
      8'h3A: w_char = 8'h6D;  8'h31: w_char = 8'h6E;  8'h44: w_char = 8'h6F;
      8'h4D: w_char = 8'h70;  8'h15: w_char = 8'h71;  8'h2D: w_char = 8'h72;
      8'h1B: w_char = 8'h73;  8'h2C: w_char = 8'h74;  8'h3C: w_char = 8'h75;
      8'h2A: w_char = 8'h76;  8'h1D: w_char = 8'h77;  8'h22: w_char = 8'h78;
      8'h35: w_char = 8'h79;  8'h1A: w_char = 8'h7A;
      default: begin
        w_letter = 1'b0;
        case (code)
          8'h16: w_char = shift ? 8'h21 : 8'h31;
          8'h1E: w_char = shift ? 8'h40 : 8'h32;
          8'h26: w_char = shift ? 8'h23 : 8'h33;
          8'h25: w_char = shift ? 8'h24 : 8'h34;
          8'h2E: w_char = shift ? 8'h25 : 8'h35;
          8'h36: w_char = shift ? 8'h5E : 8'h36;
          8'h3D: w_char = shift ? 8'h26 : 8'h37;
          8'h3E: w_char = shift ? 8'h2A : 8'h38;
          8'h46: w_char = shift ? 8'h28 : 8'h39;
          8'h45: w_char = shift ? 8'h29 : 8'h30;
          8'h29: w_char = 8'h20;
          8'h5A: w_char = 8'h0D;
          8'h66: w_char = 8'h08;
          default: hit = 1'b0;
        endcase
      end
    endcase
    // Letters are stored lowercase; shifted column is the uppercase range.
    ascii = (w_letter && shift) ? (w_char - 8'h20) : w_char;
  end

endmodule

// File: rtl/ps2_scancode_ascii.sv
// PS/2 Set-2 scancode stream to ASCII strobe, tracking F0/E0 prefixes with a timeout.
// Optional macro PS2_SHIFT_EN adds left/right shift tracking and the shifted column.
module ps2_scancode_ascii
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_i,
  input  logic       code_valid_i,
  output logic [7:0] ascii_o,
  output logic       ascii_valid_o,
  output logic       unmapped_o,
  output logic       busy_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_BRK     = ST_BRK;
  localparam logic [1:0] S_EXT     = ST_EXT;
  localparam logic [1:0] S_EXT_BRK = ST_EXT_BRK;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_ascii;
  logic             r_ascii_valid;
  logic             r_unmapped;
  logic             w_shift;
  logic             w_is_shift;
  logic             w_hit;
  logic [7:0]       w_ascii;

`ifdef PS2_SHIFT_EN
  logic r_lshift;
  logic r_rshift;
  assign w_shift    = r_lshift | r_rshift;
  assign w_is_shift = (code_i == PS2_LSHIFT) || (code_i == PS2_RSHIFT);
`else
  assign w_shift    = 1'b0;
  assign w_is_shift = 1'b0;
`endif

  ps2_ascii_lut u_lut (
    .code  (code_i),
    .shift (w_shift),
    .ascii (w_ascii),
    .hit   (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ascii       <= 8'h00;
      r_ascii_valid <= 1'b0;
      r_unmapped    <= 1'b0;
`ifdef PS2_SHIFT_EN
      r_lshift      <= 1'b0;
      r_rshift      <= 1'b0;
`endif
    end else begin
      r_ascii_valid <= 1'b0;
      r_unmapped    <= 1'b0;
      if (r_state == S_IDLE) begin
        if (code_valid_i) begin
          r_cnt <= '0;
          if (code_i == PS2_BREAK) begin
            r_state <= S_BRK;
          end else if (code_i == PS2_EXT) begin
            r_state <= S_EXT;
          end else if (w_is_shift) begin
`ifdef PS2_SHIFT_EN
            if (code_i == PS2_LSHIFT) r_lshift <= 1'b1;
            else                      r_rshift <= 1'b1;
`endif
          end else if (w_hit) begin
            r_ascii       <= w_ascii;
            r_ascii_valid <= 1'b1;
          end else begin
            r_unmapped <= 1'b1;
          end
        end
      end else if (code_valid_i) begin
        // A byte on the expiry cycle still belongs to the pending prefix.
        r_cnt   <= '0;
        r_state <= S_IDLE;
        if (r_state == S_EXT && code_i == PS2_BREAK) begin
          r_state <= S_EXT_BRK;
        end
`ifdef PS2_SHIFT_EN
        if (r_state == S_BRK && code_i == PS2_LSHIFT) r_lshift <= 1'b0;
        if (r_state == S_BRK && code_i == PS2_RSHIFT) r_rshift <= 1'b0;
`endif
      end else if (r_cnt == CNT_LAST) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ascii_o       = r_ascii;
  assign ascii_valid_o = r_ascii_valid;
  assign unmapped_o    = r_unmapped;
  assign busy_o        = (r_state != S_IDLE);
  assign state_o       = r_state;

endmodule

// File: tb/tb_ps2_scancode_ascii.sv
// Bench for ps2_scancode_ascii: byte-by-byte vector table plus timeout, back-to-back and reset sequences.
module tb_ps2_scancode_ascii;
  import ps2_pkg::*;

  localparam int T = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code;
  logic       code_valid;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       unmapped;
  logic       busy;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] code;
    int         gap;
    logic       exp_v;
    logic       exp_u;
    logic [7:0] exp_a;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  ps2_scancode_ascii #(.TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst           (rst),
    .code_i        (code),
    .code_valid_i  (code_valid),
    .ascii_o       (ascii),
    .ascii_valid_o (ascii_valid),
    .unmapped_o    (unmapped),
    .busy_o        (busy),
    .state_o       (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // scoreboard: every ascii strobe must match the next expected character
  always @(negedge clk) begin
    if (ascii_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_spurious: strobe with ascii=%h, required no strobe", ascii);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (ascii !== e) begin
          errors++;
          $display("FAIL sb_ascii: got %h, required %h", ascii, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // driver: called at a negedge, byte is sampled on the next posedge, returns at the following negedge
  task automatic send(input logic [7:0] b);
    code       = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    code       = 8'h00;
  endtask

  task automatic add(input logic [7:0] c, input int gap, input logic v, input logic u,
                     input logic [7:0] a, input logic [1:0] st);
    vecs[n_vec] = '{code: c, gap: gap, exp_v: v, exp_u: u, exp_a: a, exp_st: st};
    n_vec++;
  endtask

  initial begin
    rst        = 1'b1;
    code       = 8'h00;
    code_valid = 1'b0;

    add(8'h1C,   0, 1, 0, 8'h61, ST_IDLE);
    add(8'hF0, 100, 0, 0, 8'h61, ST_BRK);
    add(8'h1C,   0, 0, 0, 8'h61, ST_IDLE);
    add(8'hE0,   0, 0, 0, 8'h61, ST_EXT);
    add(8'h75,   0, 0, 0, 8'h61, ST_IDLE);
    add(8'hE0,   0, 0, 0, 8'h61, ST_EXT);
    add(8'hF0,   0, 0, 0, 8'h61, ST_EXT_BRK);
    add(8'h75,   0, 0, 0, 8'h61, ST_IDLE);
    add(8'h16,   0, 1, 0, 8'h31, ST_IDLE);
    add(8'h0E,   0, 0, 1, 8'h31, ST_IDLE);
    add(8'h32,   0, 1, 0, 8'h62, ST_IDLE);
    add(8'h45,   0, 1, 0, 8'h30, ST_IDLE);
    add(8'h29,   0, 1, 0, 8'h20, ST_IDLE);
    add(8'h5A,   0, 1, 0, 8'h0D, ST_IDLE);
    add(8'h66,   0, 1, 0, 8'h08, ST_IDLE);
    add(8'h1A,   0, 1, 0, 8'h7A, ST_IDLE);
    add(8'hF0,   0, 0, 0, 8'h7A, ST_BRK);
    add(8'hF0,   0, 0, 0, 8'h7A, ST_IDLE);
    add(8'h1C,   0, 1, 0, 8'h61, ST_IDLE);
`ifdef PS2_SHIFT_EN
    add(8'h12,   0, 0, 0, 8'h61, ST_IDLE);
    add(8'h1C,   0, 1, 0, 8'h41, ST_IDLE);
    add(8'h12,   0, 0, 0, 8'h41, ST_IDLE);
    add(8'h16,   0, 1, 0, 8'h21, ST_IDLE);
    add(8'hF0,   0, 0, 0, 8'h21, ST_BRK);
    add(8'h12,   0, 0, 0, 8'h21, ST_IDLE);
    add(8'h1C,   0, 1, 0, 8'h61, ST_IDLE);
    add(8'h59,   0, 0, 0, 8'h61, ST_IDLE);
    add(8'h1A,   0, 1, 0, 8'h5A, ST_IDLE);
    add(8'hF0,   0, 0, 0, 8'h5A, ST_BRK);
    add(8'h59,   0, 0, 0, 8'h5A, ST_IDLE);
    add(8'h1E,   0, 1, 0, 8'h32, ST_IDLE);
`else
    add(8'h12,   0, 0, 1, 8'h61, ST_IDLE);
    add(8'h1C,   0, 1, 0, 8'h61, ST_IDLE);
    add(8'h59,   0, 0, 1, 8'h61, ST_IDLE);
    add(8'h1E,   0, 1, 0, 8'h32, ST_IDLE);
`endif

    // reset
    repeat (3) @(negedge clk);
    chk("rst_ascii", ascii, 8'h00);
    chk("rst_valid", {7'd0, ascii_valid}, 8'h00);
    chk("rst_unmapped", {7'd0, unmapped}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_state", {6'd0, state_dbg}, {6'd0, ST_IDLE});
    rst = 1'b0;
    @(negedge clk);

    // vector table
    for (int i = 0; i < n_vec; i++) begin
      if (vecs[i].exp_v) exp_q.push_back(vecs[i].exp_a);
      send(vecs[i].code);
      chk($sformatf("v%0d_valid", i), {7'd0, ascii_valid}, {7'd0, vecs[i].exp_v});
      chk($sformatf("v%0d_unmapped", i), {7'd0, unmapped}, {7'd0, vecs[i].exp_u});
      chk($sformatf("v%0d_ascii", i), ascii, vecs[i].exp_a);
      chk($sformatf("v%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].exp_st != ST_IDLE});
      chk($sformatf("v%0d_state", i), {6'd0, state_dbg}, {6'd0, vecs[i].exp_st});
      @(negedge clk);
      chk($sformatf("v%0d_one_cycle", i), {6'd0, ascii_valid, unmapped}, 8'h00);
      repeat (vecs[i].gap) @(negedge clk);
    end

    // back-to-back typematic repeat: two strobes on consecutive cycles
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h61);
    code = 8'h1C; code_valid = 1'b1;
    @(negedge clk);
    chk("b2b_first", {7'd0, ascii_valid}, 8'h01);
    @(negedge clk);
    code_valid = 1'b0;
    chk("b2b_second", {7'd0, ascii_valid}, 8'h01);
    @(negedge clk);
    chk("b2b_end", {7'd0, ascii_valid}, 8'h00);

    // back-to-back break then make at full rate
    code = 8'hF0; code_valid = 1'b1;
    @(negedge clk);
    code = 8'h1C;
    @(negedge clk);
    chk("b2b_brk_nostrobe", {7'd0, ascii_valid}, 8'h00);
    exp_q.push_back(8'h35);
    code = 8'h2E;
    @(negedge clk);
    code_valid = 1'b0;
    chk("b2b_make_valid", {7'd0, ascii_valid}, 8'h01);
    chk("b2b_make_ascii", ascii, 8'h35);
    @(negedge clk);

    // timeout: busy holds for T cycles after F0 then falls
    send(8'hF0);
    repeat (T - 1) @(negedge clk);
    chk("to_busy_before", {7'd0, busy}, 8'h01);
    @(negedge clk);
    chk("to_busy_after", {7'd0, busy}, 8'h00);
    exp_q.push_back(8'h61);
    send(8'h1C);
    chk("to_make_valid", {7'd0, ascii_valid}, 8'h01);
    chk("to_make_ascii", ascii, 8'h61);
    @(negedge clk);

    // byte on the expiry cycle is a break, not a make
    send(8'hF0);
    repeat (T - 1) @(negedge clk);
    send(8'h1C);
    chk("exp_nostrobe", {7'd0, ascii_valid}, 8'h00);
    chk("exp_busy", {7'd0, busy}, 8'h00);
    chk("exp_ascii_held", ascii, 8'h61);
    @(negedge clk);

    // reset mid-sequence
    send(8'hE0);
    chk("mid_busy", {7'd0, busy}, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {7'd0, busy}, 8'h00);
    chk("mid_rst_ascii", ascii, 8'h00);
    exp_q.push_back(8'h61);
    send(8'h1C);
    chk("mid_make_valid", {7'd0, ascii_valid}, 8'h01);
    chk("mid_make_ascii", ascii, 8'h61);

    // unmapped after reset keeps ascii
    send(8'h0E);
    chk("unm_pulse", {7'd0, unmapped}, 8'h01);
    chk("unm_ascii", ascii, 8'h61);
    @(negedge clk);
    chk("unm_one_cycle", {7'd0, unmapped}, 8'h00);

    repeat (4) @(negedge clk);
    chk("sb_empty", 8'(exp_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
